// File: rtl/button_debounce_if.sv
// button_debounce_if: raw switch levels toward the debouncer, clean level and
// one-cycle press/release pulses toward the run/step control FSM.
interface button_debounce_if #(
    parameter int N_BUTTONS = 4
);
    logic [N_BUTTONS-1:0] button_raw;
    logic [N_BUTTONS-1:0] button;
    logic [N_BUTTONS-1:0] button_press;
    logic [N_BUTTONS-1:0] button_release;
    modport master (input button_raw, output button, button_press, button_release);
    modport slave (output button_raw, input button, button_press, button_release);
endinterface

// File: rtl/button_debounce.sv
// button_debounce: per-channel 2-flop synchronizer, stability-counter debounce FSM,
// registered clean level and single-cycle press/release pulses.
module button_debounce #(
    parameter int  N_BUTTONS       = 4,
    parameter int  DEBOUNCE_CYCLES = 60000,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              resetn,
    button_debounce_if.master bus
);
    typedef enum logic [1:0] {STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW} state_e;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic             ONE_SHOT = DEBOUNCE_CYCLES == 1;
    logic [N_BUTTONS-1:0] sync0_q, sync1_q, button_q, press_q, release_q, button_d;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync0_q <= '0;
            sync1_q <= '0;
        end else begin
            sync0_q <= bus.button_raw;
            sync1_q <= sync0_q;
        end
    end
    for (genvar c = 0; c < N_BUTTONS; c++) begin : g_ch
        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
        logic             done;
        assign cnt_inc = cnt_q + CNT_ONE;
        assign done    = cnt_inc == CNT_DONE;
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                state_q <= STABLE_LOW;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end
        // Counter is cleared on every stable-state entry and on every bounce.
        always_comb begin
            state_d = state_q;
            cnt_d   = '0;
            case (state_q)
                STABLE_LOW: begin
                    state_d = !sync1_q[c] ? STABLE_LOW : ONE_SHOT ? STABLE_HIGH : WAIT_HIGH;
                    cnt_d   = (sync1_q[c] && !ONE_SHOT) ? CNT_ONE : '0;
                end
                WAIT_HIGH: begin
                    state_d = !sync1_q[c] ? STABLE_LOW : done ? STABLE_HIGH : WAIT_HIGH;
                    cnt_d   = (sync1_q[c] && !done) ? cnt_inc : '0;
                end
                STABLE_HIGH: begin
                    state_d = sync1_q[c] ? STABLE_HIGH : ONE_SHOT ? STABLE_LOW : WAIT_LOW;
                    cnt_d   = (!sync1_q[c] && !ONE_SHOT) ? CNT_ONE : '0;
                end
                WAIT_LOW: begin
                    state_d = sync1_q[c] ? STABLE_HIGH : done ? STABLE_LOW : WAIT_LOW;
                    cnt_d   = (!sync1_q[c] && !done) ? cnt_inc : '0;
                end
                default: state_d = STABLE_LOW;
            endcase
        end
        assign button_d[c] = (state_d == STABLE_HIGH) || (state_d == WAIT_LOW);
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            button_q  <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            button_q  <= button_d;
            press_q   <= button_d & ~button_q;
            release_q <= ~button_d & button_q;
        end
    end
    assign bus.button         = button_q;
    assign bus.button_press   = press_q;
    assign bus.button_release = release_q;
endmodule
